mem_arbiter: RTL and testbench

//   Shares the single word-addressed program/data memory between two requesters:

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter_rr_pick.sv | 23 ++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: arbitration state encoding,
// port indices and the conflict counter ceiling.
package scic_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_P0   = 2'd1,
      ARB_P1   = 2'd2
   } arb_state_t;

   localparam logic        PORT_CPU     = 1'b0;
   localparam logic        PORT_DMA     = 1'b1;
   localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus between the two requesters, the arbiter and the memory macro.
// slave = arbiter view, master = requesters plus memory view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              req0, req1;
   logic              we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              lock0, lock1;
   logic              gnt0, gnt1;
   logic              rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [15:0]       conflict_cnt;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_rdata,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_we, mem_wdata, conflict_cnt
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_rdata,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_we, mem_wdata, conflict_cnt
   );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-way round-robin picker with a hold override that lets
// the current owner keep the grant. Output is one-hot or zero.
module arb_rr_pick (
   input  logic [1:0] i_req,
   input  logic       i_last_owner,
   input  logic       i_hold_en,
   input  logic       i_hold_port,
   output logic [1:0] o_gnt
);

   // NOTE: every output of an always_comb gets a default first so no latch is inferred.
   always_comb begin
      o_gnt = 2'b00;
      if (i_hold_en && i_req[i_hold_port]) begin
         o_gnt[i_hold_port] = 1'b1;
      end else if (&i_req) begin
         o_gnt[~i_last_owner] = 1'b1;
      end else begin
         o_gnt = i_req;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory between CPU (port 0) and DMA (port 1).
// Optional locked bursts are enabled by defining MEM_ARB_BURST_EN.
module mem_arbiter
   import scic_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input logic          clock,
   input logic          reset_n,
   mem_arbiter_if.slave bus
);

   arb_state_t  r_state, w_state_nxt;
   logic        r_last_owner, w_last_nxt;
   logic [1:0]  w_req, w_pick, w_gnt;
   logic        w_hold_en, w_hold_port;
   logic        r_rvalid0, r_rvalid1;
   logic [15:0] r_conflict_cnt;
   logic        w_unused_cfg;

   assign w_req        = {bus.req1, bus.req0};
   assign w_unused_cfg = (MAX_BURST > 0);

`ifdef MEM_ARB_BURST_EN
   localparam int              BCNT_W     = $clog2(MAX_BURST + 1);
   localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST - 1);

   logic [BCNT_W-1:0] r_burst_cnt, w_burst_nxt;
   logic              w_win_lock;

   assign w_hold_port = (r_state == ARB_P1);
   assign w_hold_en   = (r_state != ARB_IDLE) && (w_hold_port ? bus.lock1 : bus.lock0)
                        && (r_burst_cnt < BURST_LAST);
   assign w_win_lock  = w_gnt[PORT_DMA] ? bus.lock1 : bus.lock0;

   // Counts locked repeat grants to the same owner; saturates so the other port gets through.
   always_comb begin
      w_burst_nxt = '0;
      if ((|w_gnt) && w_win_lock && (r_state != ARB_IDLE) && (w_state_nxt == r_state)) begin
         w_burst_nxt = (r_burst_cnt < BURST_LAST) ? r_burst_cnt + 1'b1 : r_burst_cnt;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_burst_cnt <= '0;
      else          r_burst_cnt <= w_burst_nxt;
   end
`else
   logic w_unused_lock;

   assign w_hold_en     = 1'b0;
   assign w_hold_port   = 1'b0;
   assign w_unused_lock = bus.lock0 ^ bus.lock1;
`endif

   arb_rr_pick u_pick (
      .i_req        (w_req),
      .i_last_owner (r_last_owner),
      .i_hold_en    (w_hold_en),
      .i_hold_port  (w_hold_port),
      .o_gnt        (w_pick)
   );

   // Grants are forced low for the whole time reset is asserted, not only at the edge.
   assign w_gnt    = w_pick & {2{reset_n}};
   assign bus.gnt0 = w_gnt[PORT_CPU];
   assign bus.gnt1 = w_gnt[PORT_DMA];

   always_comb begin
      w_state_nxt = ARB_IDLE;
      w_last_nxt  = r_last_owner;
      if (w_gnt[PORT_CPU]) begin
         w_state_nxt = ARB_P0;
         w_last_nxt  = PORT_CPU;
      end else if (w_gnt[PORT_DMA]) begin
         w_state_nxt = ARB_P1;
         w_last_nxt  = PORT_DMA;
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ARB_IDLE;
         r_last_owner <= PORT_DMA;
      end else begin
         r_state      <= w_state_nxt;
         r_last_owner <= w_last_nxt;
      end
   end

   assign bus.mem_addr  = w_gnt[PORT_DMA] ? bus.addr1  : bus.addr0;
   assign bus.mem_wdata = w_gnt[PORT_DMA] ? bus.wdata1 : bus.wdata0;
   assign bus.mem_we    = (w_gnt[PORT_CPU] & bus.we0) | (w_gnt[PORT_DMA] & bus.we1);
   assign bus.rdata     = bus.mem_rdata;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
      end else begin
         r_rvalid0 <= w_gnt[PORT_CPU] & ~bus.we0;
         r_rvalid1 <= w_gnt[PORT_DMA] & ~bus.we1;
      end
   end

   assign bus.rvalid0 = r_rvalid0;
   assign bus.rvalid1 = r_rvalid1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_conflict_cnt <= 16'd0;
      end else if ((w_req == 2'b11) && (r_conflict_cnt != CONFLICT_MAX)) begin
         r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
   end

   assign bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural memory.
// Burst expectations follow MEM_ARB_BURST_EN when it is defined.
module tb_mem_arbiter;

   logic clock = 1'b0;
   logic reset_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

   mem_arbiter #(.MAX_BURST(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   logic [31:0] mem [0:255];

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
         mem[8'h10]    <= 32'hDEAD_BEEF;
         bus.mem_rdata <= 32'd0;
      end else begin
         if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
         bus.mem_rdata <= mem[bus.mem_addr[7:0]];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.req0 = 1'b0;  bus.req1 = 1'b0;
      bus.we0  = 1'b0;  bus.we1  = 1'b0;
      bus.lock0 = 1'b0; bus.lock1 = 1'b0;
      bus.addr0 = 16'd0; bus.addr1 = 16'd0;
      bus.wdata0 = 32'd0; bus.wdata1 = 32'd0;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      idle();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   logic [1:0] exp5 [6];

   initial begin
      idle();
      reset_n = 1'b0;
      #12;
      check("reset_gnt0", {31'd0, bus.gnt0}, 32'd0);
      check("reset_rvalid0", {31'd0, bus.rvalid0}, 32'd0);
      reset_n = 1'b1;

      // Reset arriving while a read response is in flight.
      @(negedge clock);
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      bus.addr0 = 16'h0010; bus.addr1 = 16'h0020;
      #1;
      check("t1_first_conflict", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
      @(posedge clock);
      #2;
      check("t1_rvalid_before", {31'd0, bus.rvalid0}, 32'd1);
      check("t1_cnt_before", {16'd0, bus.conflict_cnt}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("t1_rvalid0_rst", {31'd0, bus.rvalid0}, 32'd0);
      check("t1_cnt_rst", {16'd0, bus.conflict_cnt}, 32'd0);
      check("t1_gnt_rst", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
      idle();
      @(negedge clock);
      reset_n = 1'b1;

      // Single CPU read with one-cycle latency.
      @(negedge clock);
      bus.req0 = 1'b1; bus.addr0 = 16'h0010;
      #1;
      check("t2_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
      check("t2_mem_addr", {16'd0, bus.mem_addr}, 32'h10);
      check("t2_mem_we", {31'd0, bus.mem_we}, 32'd0);
      @(negedge clock);
      idle();
      #1;
      check("t2_rvalid0", {31'd0, bus.rvalid0}, 32'd1);
      check("t2_rdata", bus.rdata, 32'hDEAD_BEEF);
      check("t2_rvalid1", {31'd0, bus.rvalid1}, 32'd0);
      @(negedge clock);
      #1;
      check("t2_rvalid0_gone", {31'd0, bus.rvalid0}, 32'd0);

      // Sustained conflict alternates, idle keeps last owner.
      apply_reset();
      @(negedge clock);
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      bus.addr0 = 16'h0010; bus.addr1 = 16'h0011;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("t3_gnt_%0d", i), {30'd0, bus.gnt1, bus.gnt0},
               (i % 2 == 0) ? 32'd1 : 32'd2);
         if (i == 2) check("t3_rvalid1", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd2);
         @(negedge clock);
      end
      idle();
      #1;
      check("t3_conflict_cnt", {16'd0, bus.conflict_cnt}, 32'd4);
      @(negedge clock);
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      #1;
      check("t3_after_idle", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
      @(negedge clock);
      idle();

      // DMA write followed by CPU read of the same word.
      @(negedge clock);
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0005; bus.wdata1 = 32'h1234_5678;
      #1;
      check("t4_gnt1", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
      check("t4_mem_we", {31'd0, bus.mem_we}, 32'd1);
      check("t4_mem_addr", {16'd0, bus.mem_addr}, 32'h5);
      check("t4_mem_wdata", bus.mem_wdata, 32'h1234_5678);
      @(negedge clock);
      idle();
      bus.req0 = 1'b1; bus.addr0 = 16'h0005;
      #1;
      check("t4_gnt0", {30'd0, bus.gnt1, bus.gnt0}, 32'd1);
      check("t4_mem_we_once", {31'd0, bus.mem_we}, 32'd0);
      @(negedge clock);
      idle();
      #1;
      check("t4_rvalid0", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd1);
      check("t4_rdata", bus.rdata, 32'h1234_5678);

      // Locked requests from port 0 against a steady port 1.
`ifdef MEM_ARB_BURST_EN
      exp5[0] = 2'b01; exp5[1] = 2'b01; exp5[2] = 2'b01;
      exp5[3] = 2'b01; exp5[4] = 2'b10; exp5[5] = 2'b01;
`else
      exp5[0] = 2'b01; exp5[1] = 2'b10; exp5[2] = 2'b01;
      exp5[3] = 2'b10; exp5[4] = 2'b01; exp5[5] = 2'b10;
`endif
      apply_reset();
      @(negedge clock);
      bus.req0 = 1'b1; bus.req1 = 1'b1; bus.lock0 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         check($sformatf("t5_gnt_%0d", i), {30'd0, bus.gnt1, bus.gnt0}, {30'd0, exp5[i]});
         @(negedge clock);
      end
      idle();

      // Conflict counter saturation.
      apply_reset();
      @(negedge clock);
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      repeat (65534) @(negedge clock);
      #1;
      check("t6_cnt_fffe", {16'd0, bus.conflict_cnt}, 32'h0000_FFFE);
      @(negedge clock);
      #1;
      check("t6_cnt_ffff", {16'd0, bus.conflict_cnt}, 32'h0000_FFFF);
      repeat (2) @(negedge clock);
      #1;
      check("t6_cnt_hold", {16'd0, bus.conflict_cnt}, 32'h0000_FFFF);
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
